// File: rtl/pid_pwm_out.sv
// Converts the PID core's u(n) into a saturated duty count and an edge-aligned, period-synchronous PWM pair.
// Optional dead-time insertion is built when PWM_DEADTIME_EN is defined.
module pid_pwm_out #(
    parameter int unsigned cnt_nb = 16,
    parameter int unsigned dt_nb  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_un,
    input  logic              i_valid,
    input  logic              i_en,
    input  logic [cnt_nb-1:0] i_period,
    input  logic [4:0]        i_shift,
    input  logic [dt_nb-1:0]  i_deadtime,
    output logic              o_pwm_h,
    output logic              o_pwm_l,
    output logic [cnt_nb-1:0] o_duty,
    output logic              o_sat,
    output logic              o_pstart
);

    logic              valid_q;
    logic              armed_q;
    logic              cap_q;
    logic [31:0]       un_q;
    logic [cnt_nb-1:0] pend_q;
    logic              sat_q;
    logic [cnt_nb-1:0] per_q;
    logic [cnt_nb-1:0] duty_q;
    logic [cnt_nb-1:0] cnt_q;
    logic              pstart_q;
    logic              pwm_h_q;
    logic              pwm_l_q;

    logic                     cap;
    logic                     load;
    logic                     raw_d;
    logic                     pstart_d;
    logic [cnt_nb-1:0]        cnt_d;
    logic [cnt_nb-1:0]        pend_d;
    logic                     sat_d;
    logic signed [31:0]       s_sh;
    logic signed [32:0]       s_ext;
    logic signed [32:0]       per_ext;

    always_comb begin
        // armed_q blocks a capture until i_valid has been seen low after reset
        cap     = i_valid & ~valid_q & armed_q;
        s_sh    = $signed(un_q) >>> i_shift;
        s_ext   = {s_sh[31], s_sh};
        per_ext = {{(33 - cnt_nb){1'b0}}, per_q};

        pend_d = pend_q;
        sat_d  = sat_q;
        if (cap_q) begin
            if (s_ext[32]) begin
                pend_d = '0;
                sat_d  = 1'b1;
            end else if (s_ext > per_ext) begin
                pend_d = per_q;
                sat_d  = 1'b1;
            end else begin
                pend_d = s_sh[cnt_nb-1:0];
                sat_d  = 1'b0;
            end
        end

        // A zero period reloads every cycle so a new period can be picked up
        load     = ~i_en | (per_q == '0) | (cnt_q == per_q - cnt_nb'(1));
        cnt_d    = load ? '0 : cnt_q + cnt_nb'(1);
        raw_d    = i_en & (per_q != '0) & (cnt_q < duty_q);
        pstart_d = i_en & (per_q != '0) & (cnt_q == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            armed_q  <= 1'b0;
            cap_q    <= 1'b0;
            un_q     <= '0;
            pend_q   <= '0;
            sat_q    <= 1'b0;
            per_q    <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            pstart_q <= 1'b0;
        end else begin
            valid_q  <= i_valid;
            armed_q  <= armed_q | ~i_valid;
            cap_q    <= cap;
            if (cap) begin
                un_q <= i_un;
            end
            pend_q   <= pend_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            if (load) begin
                per_q  <= i_period;
                duty_q <= pend_q;
            end
            pstart_q <= pstart_d;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic             raw_q;
    logic [dt_nb-1:0] run_q;
    logic [dt_nb-1:0] run_d;
    logic             dt_ok;

    always_comb begin
        // Cycles spent at the current raw level before this one, saturating
        if (raw_d != raw_q) begin
            run_d = '0;
        end else if (run_q == '1) begin
            run_d = run_q;
        end else begin
            run_d = run_q + dt_nb'(1);
        end
        dt_ok = (run_d >= i_deadtime);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            raw_q   <= 1'b0;
            run_q   <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            raw_q   <= raw_d;
            run_q   <= run_d;
            pwm_h_q <= raw_d & dt_ok;
            pwm_l_q <= ~raw_d & i_en & dt_ok;
        end
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = ^i_deadtime;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            pwm_h_q <= raw_d;
            pwm_l_q <= ~raw_d & i_en;
        end
    end
`endif

    assign o_pwm_h  = pwm_h_q;
    assign o_pwm_l  = pwm_l_q;
    assign o_duty   = duty_q;
    assign o_sat    = sat_q;
    assign o_pstart = pstart_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Self-checking bench for pid_pwm_out: directed scenarios plus randomized stimulus against a
// cycle-level behavioural model built from integer arithmetic.
module tb_pid_pwm_out;

    localparam int CNT = 16;

    logic           clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [31:0]    i_un = '0;
    logic           i_valid = 1'b0;
    logic           i_en = 1'b0;
    logic [CNT-1:0] i_period = '0;
    logic [4:0]     i_shift = '0;
    logic [7:0]     i_deadtime = '0;
    logic           o_pwm_h, o_pwm_l, o_sat, o_pstart;
    logic [CNT-1:0] o_duty;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pid_pwm_out dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_un       (i_un),
        .i_valid    (i_valid),
        .i_en       (i_en),
        .i_period   (i_period),
        .i_shift    (i_shift),
        .i_deadtime (i_deadtime),
        .o_pwm_h    (o_pwm_h),
        .o_pwm_l    (o_pwm_l),
        .o_duty     (o_duty),
        .o_sat      (o_sat),
        .o_pstart   (o_pstart)
    );

    // Reference model: phase within the period, floor-division scaling, clamping
    logic [31:0] m_un = '0;
    bit m_lastv = 1, m_capp = 0, m_sat = 0, m_h = 0, m_l = 0, m_pst = 0, m_raw = 0;
    int m_per = 0, m_duty = 0, m_pend = 0, m_phase = 0, m_run = 0;

    always @(posedge clk) begin
        if (i_rst) begin
            m_un = '0; m_lastv = 1; m_capp = 0; m_sat = 0; m_h = 0; m_l = 0; m_pst = 0;
            m_raw = 0; m_per = 0; m_duty = 0; m_pend = 0; m_phase = 0; m_run = 0;
        end else begin
            longint v, d, s;
            bit raw, cap, wrap, nsat;
            int npend;
            cap   = i_valid && !m_lastv;
            raw   = i_en && m_per != 0 && m_phase < m_duty;
            m_pst = i_en && m_per != 0 && m_phase == 0;
            wrap  = !i_en || m_per == 0 || m_phase == m_per - 1;
            npend = m_pend;
            nsat  = m_sat;
            if (m_capp) begin
                v = longint'($signed(m_un));
                d = longint'(1) << i_shift;
                s = (v >= 0) ? v / d : -((-v + d - 1) / d);
                if (s < 0) begin
                    npend = 0; nsat = 1;
                end else if (s > m_per) begin
                    npend = m_per; nsat = 1;
                end else begin
                    npend = int'(s); nsat = 0;
                end
            end
            if (wrap) begin
                m_duty = m_pend; m_per = int'(i_period); m_phase = 0;
            end else begin
                m_phase++;
            end
            m_pend = npend;
            m_sat  = nsat;
            if (cap) m_un = i_un;
            m_capp  = cap;
            m_lastv = i_valid;
`ifdef PWM_DEADTIME_EN
            m_run = (raw != m_raw) ? 0 : (m_run < 255 ? m_run + 1 : 255);
            m_h   = raw && m_run >= int'(i_deadtime);
            m_l   = !raw && i_en && m_run >= int'(i_deadtime);
`else
            m_h = raw;
            m_l = !raw && i_en;
`endif
            m_raw = raw;
        end
    end

    logic [CNT+3:0] dut_vec, exp_vec;
    assign dut_vec = {o_pwm_h, o_pwm_l, o_sat, o_pstart, o_duty};
    assign exp_vec = {m_h, m_l, m_sat, m_pst, CNT'(m_duty)};

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic new_sample(input logic [31:0] un);
        i_valid = 1'b0;
        cycle();
        i_un    = un;
        i_valid = 1'b1;
    endtask

    task automatic wait_pstart(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            if (o_pstart === 1'b1) ok = 1;
        end
    endtask

    task automatic measure(input int n, output int hi, output int lo, output int both,
                           output int pst);
        hi = 0; lo = 0; both = 0; pst = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) cycle();
            hi   += int'(o_pwm_h === 1'b1);
            lo   += int'(o_pwm_l === 1'b1);
            both += int'(o_pwm_h === 1'b1 && o_pwm_l === 1'b1);
            pst  += int'(o_pstart === 1'b1);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (dut_vec !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected 0", dut_vec);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        int hi, lo, both, pst;
        bit ok;
        i_period = 10; i_shift = 0; i_en = 1'b1;
        new_sample(32'd4);
        for (int i = 0; i < 30; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL basic_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        wait_pstart(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL basic_pstart_timeout: got none expected 1"); end
        measure(10, hi, lo, both, pst);
        n_checks += 3;
        if (hi != 4 || pst != 1) begin
            n_errors++;
            $display("FAIL basic_duty_cycle: got hi=%0d pst=%0d expected hi=4 pst=1", hi, pst);
        end
        if (o_duty !== 16'd4) begin n_errors++; $display("FAIL basic_o_duty: got %0d expected 4", o_duty); end
        if (o_sat !== 1'b0) begin n_errors++; $display("FAIL basic_o_sat: got %b expected 0", o_sat); end
    endtask

    task automatic test_saturation();
        int hi, lo, both, pst;
        bit ok;
        new_sample(32'hFFFF_FFF0);
        repeat (25) cycle();
        wait_pstart(ok);
        measure(10, hi, lo, both, pst);
        n_checks++;
        if (!ok || o_duty !== 16'd0 || o_sat !== 1'b1 || hi != 0) begin
            n_errors++;
            $display("FAIL sat_negative: got duty=%0d sat=%b hi=%0d expected duty=0 sat=1 hi=0",
                     o_duty, o_sat, hi);
        end
        new_sample(32'd50);
        repeat (25) cycle();
        wait_pstart(ok);
        measure(10, hi, lo, both, pst);
        n_checks++;
        if (!ok || o_duty !== 16'd10 || o_sat !== 1'b1 || hi != 10) begin
            n_errors++;
            $display("FAIL sat_high: got duty=%0d sat=%b hi=%0d expected duty=10 sat=1 hi=10",
                     o_duty, o_sat, hi);
        end
    endtask

    task automatic test_shift();
        i_shift = 5'd4;
        new_sample(32'h60);
        for (int i = 0; i < 25; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL shift_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (o_duty !== 16'd6 || o_sat !== 1'b0) begin
            n_errors++;
            $display("FAIL shift_pos: got duty=%0d sat=%b expected duty=6 sat=0", o_duty, o_sat);
        end
        new_sample(-32'h60);
        repeat (25) cycle();
        n_checks++;
        if (o_duty !== 16'd0 || o_sat !== 1'b1) begin
            n_errors++;
            $display("FAIL shift_neg: got duty=%0d sat=%b expected duty=0 sat=1", o_duty, o_sat);
        end
        i_shift = 5'd0;
    endtask

    task automatic test_glitch_free();
        int hi1, hi2;
        bit ok;
        new_sample(32'd2);
        repeat (25) cycle();
        wait_pstart(ok);
        hi1 = 0; hi2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cycle();
            if (i < 10) hi1 += int'(o_pwm_h === 1'b1);
            else        hi2 += int'(o_pwm_h === 1'b1);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL glitch_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            if (i == 4) i_valid = 1'b0;
            if (i == 5) begin i_valid = 1'b1; i_un = 32'd8; end
        end
        n_checks++;
        if (!ok || hi1 != 2 || hi2 != 8) begin
            n_errors++;
            $display("FAIL glitch_free: got %0d/%0d expected 2/8", hi1, hi2);
        end
    endtask

    task automatic test_edge_only();
        new_sample(32'd3);
        repeat (25) cycle();
        i_un = 32'd7;
        for (int i = 0; i < 25; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL edge_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (o_duty !== 16'd3) begin
            n_errors++;
            $display("FAIL edge_only: got duty=%0d expected 3", o_duty);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_pstart(ok);
        repeat (3) cycle();
        i_rst = 1'b1;
        cycle();
        n_checks++;
        if (!ok || dut_vec !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got %h expected 0", dut_vec);
        end
        i_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL reset_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (o_duty !== 16'd0 || o_sat !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_capture: got duty=%0d sat=%b expected 0 0", o_duty, o_sat);
        end
        new_sample(32'd5);
        repeat (25) cycle();
        n_checks++;
        if (o_duty !== 16'd5) begin
            n_errors++;
            $display("FAIL reset_recapture: got duty=%0d expected 5", o_duty);
        end
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadtime();
        int hi, lo, both, pst;
        bit ok;
        i_period = 20; i_deadtime = 8'd2;
        new_sample(32'd10);
        repeat (45) cycle();
        wait_pstart(ok);
        measure(20, hi, lo, both, pst);
        n_checks++;
        if (!ok || hi != 8 || lo != 8 || both != 0) begin
            n_errors++;
            $display("FAIL deadtime: got h=%0d l=%0d both=%0d expected 8 8 0", hi, lo, both);
        end
        i_deadtime = 8'd0;
        i_period = 10;
    endtask
`endif

    task automatic test_random();
        i_en = 1'b1; i_period = 8;
        for (int i = 0; i < 1500; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL random_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            i_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) i_en = ~i_en;
            if ($urandom_range(0, 5) == 0) i_valid = ~i_valid;
            case ($urandom_range(0, 3))
                0:       i_un = $urandom();
                1:       i_un = 32'($urandom_range(0, 15));
                2:       i_un = -32'($urandom_range(0, 20));
                default: i_un = 32'($urandom_range(0, 40));
            endcase
            if ($urandom_range(0, 39) == 0) i_period = CNT'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) i_shift = 5'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) i_deadtime = 8'($urandom_range(0, 3));
        end
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_shift();
        test_glitch_free();
        test_edge_only();
        test_reset_mid();
`ifdef PWM_DEADTIME_EN
        test_deadtime();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
